// File: rtl/regfile_pkg.sv
// Shared constants, defaults and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned REG_ZERO  = 0;
  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  typedef logic [clog2(NREGS_DEF)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/issue/writeback bus of the multi-port register file.
interface regfile_mp_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [NUM_RD*AW-1:0]   rd_addr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_addr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic [NREGS-1:0]       busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writeback clears, issue wins on a tie.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NUM_WR = 1,
  parameter int unsigned AW     = clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]     busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;

  always_comb begin
    set_v  = '0;
    clr_v  = '0;
    busy_d = busy_q;
    for (int unsigned r = 1; r < NREGS; r++) begin
      set_v[r] = iss_en && (iss_addr == AW'(r));
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) clr_v[r] = 1'b1;
      end
      if (set_v[r])      busy_d[r] = 1'b1;
      else if (clr_v[r]) busy_d[r] = 1'b0;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with busy scoreboard.
// Optional write-to-read forwarding when REGFILE_MP_BYPASS_EN is defined.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREGS  = NREGS_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);

  localparam int unsigned AW = clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic [NREGS-1:0] busy_vec;
  logic [AW-1:0]    ra;
`ifdef REGFILE_MP_BYPASS_EN
  logic             hit;
`endif

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NUM_WR (NUM_WR),
    .AW     (AW)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (bus.iss_en),
    .iss_addr (bus.iss_addr),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .busy_vec (busy_vec)
  );

  // Ascending port order lets the higher-index port win a same-address conflict.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] != ZERO_ADDR))
        mem_d[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= mem_d[r];
    end
  end

  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
`ifdef REGFILE_MP_BYPASS_EN
    hit         = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      bus.rd_data[i*XLEN +: XLEN] = (ra == ZERO_ADDR) ? '0 : mem_q[ra];
      bus.rd_busy[i]              = busy_vec[ra];
`ifdef REGFILE_MP_BYPASS_EN
      // Forwarding is gated by reset so reads stay zero while it is held.
      hit = 1'b0;
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (!reset && bus.wr_en[j] && (ra != ZERO_ADDR) &&
            (bus.wr_addr[j*AW +: AW] == ra)) begin
          bus.rd_data[i*XLEN +: XLEN] = bus.wr_data[j*XLEN +: XLEN];
          hit = 1'b1;
        end
      end
      if (hit && !(bus.iss_en && (bus.iss_addr == ra))) bus.rd_busy[i] = 1'b0;
`endif
    end
  end

  assign bus.busy_vec = busy_vec;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table plus randomized model comparison.
module tb_regfile_mp;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) bus_a ();
  regfile_mp_if #(.XLEN(64), .NREGS(16), .NUM_RD(4), .NUM_WR(2)) bus_b ();

  regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  regfile_mp #(.XLEN(64), .NREGS(16), .NUM_RD(4), .NUM_WR(2)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        ie;
    logic [4:0]  ia;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic [31:0] ebv;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic ie, input logic [4:0] ia,
                              input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] eb, input logic [31:0] ebv);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.ie = ie; v.ia = ia; v.ra0 = ra0; v.ra1 = ra1;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.ebv = ebv;
    return v;
  endfunction

  task automatic idle_a();
    bus_a.wr_en = '0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.iss_en = 1'b0; bus_a.iss_addr = '0; bus_a.rd_addr = '0;
  endtask

  task automatic idle_b();
    bus_b.wr_en = '0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.iss_en = 1'b0; bus_b.iss_addr = '0; bus_b.rd_addr = '0;
  endtask

  // Reference model for the 64-bit / 16-register instance
  logic [63:0] m_mem  [16];
  logic        m_busy [16];

  vec_t tbl [13];

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    idle_a();
    idle_b();
    for (int r = 0; r < 16; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end

    tbl[0]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 2'b00, 0);
    tbl[1]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 2, 0, 0, 2'b00, 0);
    tbl[2]  = mk(2'b01, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 0);
    tbl[3]  = mk(2'b11, 7, 32'h11, 7, 32'h22, 0, 0, 0, 5, 0, 32'hDEADBEEF, 2'b00, 0);
    tbl[4]  = mk(2'b00, 0, 0, 0, 0, 1, 3, 7, 7, 32'h22, 32'h22, 2'b00, 0);
    tbl[5]  = mk(2'b01, 3, 32'h55, 0, 0, 1, 3, 7, 0, 32'h22, 0, 2'b00, 32'h8);
    tbl[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 3, 7, 32'h55, 32'h22, 2'b01, 32'h8);
    tbl[7]  = mk(2'b10, 0, 0, 3, 32'h77, 0, 0, 7, 0, 32'h22, 0, 2'b00, 32'h8);
    tbl[8]  = mk(2'b11, 10, 32'hA, 11, 32'hB, 0, 0, 3, 3, 32'h77, 32'h77, 2'b00, 0);
    tbl[9]  = mk(2'b00, 0, 0, 0, 0, 1, 31, 10, 11, 32'hA, 32'hB, 2'b00, 0);
    tbl[10] = mk(2'b00, 0, 0, 0, 0, 0, 0, 31, 10, 0, 32'hA, 2'b01, 32'h80000000);
    tbl[11] = mk(2'b01, 31, 32'h1234, 0, 0, 0, 0, 10, 11, 32'hA, 32'hB, 2'b00, 32'h80000000);
    tbl[12] = mk(2'b00, 0, 0, 0, 0, 0, 0, 31, 31, 32'h1234, 32'h1234, 2'b00, 0);

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed table; no vector reads an address written in the same cycle
    for (int k = 0; k < 13; k++) begin
      if (k != 0) @(negedge clk);
      bus_a.wr_en    = tbl[k].we;
      bus_a.wr_addr  = {tbl[k].wa1, tbl[k].wa0};
      bus_a.wr_data  = {tbl[k].wd1, tbl[k].wd0};
      bus_a.iss_en   = tbl[k].ie;
      bus_a.iss_addr = tbl[k].ia;
      bus_a.rd_addr  = {tbl[k].ra1, tbl[k].ra0};
      #1;
      chk($sformatf("tbl%0d_rd0", k), 64'(bus_a.rd_data[31:0]), 64'(tbl[k].e0));
      chk($sformatf("tbl%0d_rd1", k), 64'(bus_a.rd_data[63:32]), 64'(tbl[k].e1));
      chk($sformatf("tbl%0d_busy", k), 64'(bus_a.rd_busy), 64'(tbl[k].eb));
      chk($sformatf("tbl%0d_bvec", k), 64'(bus_a.busy_vec), 64'(tbl[k].ebv));
    end

    // Forwarding sequence on x9 while it is busy
    @(negedge clk);
    idle_a();
    bus_a.wr_en = 2'b01; bus_a.wr_addr = {5'd0, 5'd9}; bus_a.wr_data = {32'd0, 32'h1};
    bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd9;
    @(negedge clk);
    idle_a();
    bus_a.wr_en = 2'b01; bus_a.wr_addr = {5'd0, 5'd9}; bus_a.wr_data = {32'd0, 32'hABCD};
    bus_a.rd_addr = {5'd9, 5'd9};
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("byp_same_rd", 64'(bus_a.rd_data[31:0]), 64'hABCD);
    chk("byp_same_busy", 64'(bus_a.rd_busy), 64'h0);
`else
    chk("byp_same_rd", 64'(bus_a.rd_data[31:0]), 64'h1);
    chk("byp_same_busy", 64'(bus_a.rd_busy), 64'h3);
`endif
    @(negedge clk);
    idle_a();
    bus_a.rd_addr = {5'd9, 5'd9};
    #1;
    chk("byp_next_rd", 64'(bus_a.rd_data[63:32]), 64'hABCD);
    chk("byp_next_busy", 64'(bus_a.rd_busy), 64'h0);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    idle_a();
    bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd4;
    @(negedge clk);
    idle_a();
    bus_a.rd_addr = {5'd0, 5'd5};
    #1;
    chk("pre_rst_rd", 64'(bus_a.rd_data[31:0]), 64'hDEADBEEF);
    chk("pre_rst_bvec", 64'(bus_a.busy_vec), 64'h10);
    #1 reset = 1'b1;
    #1;
    chk("rst_async_rd", 64'(bus_a.rd_data[31:0]), 64'h0);
    chk("rst_async_bvec", 64'(bus_a.busy_vec), 64'h0);
    bus_a.wr_en = 2'b01; bus_a.wr_addr = {5'd0, 5'd6}; bus_a.wr_data = {32'd0, 32'h99};
    bus_a.iss_en = 1'b1; bus_a.iss_addr = 5'd6; bus_a.rd_addr = {5'd6, 5'd6};
    #1;
    chk("rst_hold_rd", 64'(bus_a.rd_data), 64'h0);
    @(posedge clk);
    #1;
    chk("rst_edge_bvec", 64'(bus_a.busy_vec), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_a();
    bus_a.rd_addr = {5'd6, 5'd5};
    #1;
    chk("post_rst_x6", 64'(bus_a.rd_data[31:0]), 64'h0);
    chk("post_rst_x5", 64'(bus_a.rd_data[63:32]), 64'h0);

    // Randomized run on the wide instance against the array model
    for (int c = 0; c < 10000; c++) begin
      logic [1:0]  we;
      logic [3:0]  wa [2];
      logic [63:0] wd [2];
      logic        ie;
      logic [3:0]  ia;
      logic [3:0]  ra [4];
      @(negedge clk);
      we = 2'($urandom_range(0, 3));
      ie = 1'($urandom_range(0, 1));
      ia = 4'($urandom_range(0, 15));
      for (int j = 0; j < 2; j++) begin
        wa[j] = 4'($urandom_range(0, 15));
        wd[j] = {$urandom, $urandom};
      end
      for (int i = 0; i < 4; i++) ra[i] = 4'($urandom_range(0, 15));
      bus_b.wr_en    = we;
      bus_b.wr_addr  = {wa[1], wa[0]};
      bus_b.wr_data  = {wd[1], wd[0]};
      bus_b.iss_en   = ie;
      bus_b.iss_addr = ia;
      bus_b.rd_addr  = {ra[3], ra[2], ra[1], ra[0]};
      #1;
      for (int i = 0; i < 4; i++) begin
        logic [63:0] ev;
        logic        eb;
        ev = (ra[i] == 0) ? 64'h0 : m_mem[ra[i]];
        eb = m_busy[ra[i]];
`ifdef REGFILE_MP_BYPASS_EN
        begin
          logic fwd;
          fwd = 1'b0;
          for (int j = 0; j < 2; j++) begin
            if (we[j] && wa[j] == ra[i] && ra[i] != 0) begin ev = wd[j]; fwd = 1'b1; end
          end
          if (fwd && !(ie && ia == ra[i])) eb = 1'b0;
        end
`endif
        chk($sformatf("rnd%0d_rd%0d", c, i), bus_b.rd_data[i*64 +: 64], ev);
        chk($sformatf("rnd%0d_busy%0d", c, i), 64'(bus_b.rd_busy[i]), 64'(eb));
      end
      begin
        logic [15:0] bv;
        for (int r = 0; r < 16; r++) bv[r] = m_busy[r];
        chk($sformatf("rnd%0d_bvec", c), 64'(bus_b.busy_vec), 64'(bv));
      end
      @(posedge clk);
      #1;
      for (int r = 1; r < 16; r++) begin
        logic set, clr;
        set = ie && (ia == r);
        clr = (we[0] && wa[0] == r) || (we[1] && wa[1] == r);
        if (set)      m_busy[r] = 1'b1;
        else if (clr) m_busy[r] = 1'b0;
      end
      for (int j = 0; j < 2; j++) begin
        if (we[j] && wa[j] != 0) m_mem[wa[j]] = wd[j];
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
